mul_seq_ctrl: RTL and testbench

- Multi-cycle multiply controller and datapath for the EX stage of the 5-stage RISC-V pipeline.
- Accepts a multiply request from the EX stage and runs an iterative shift-add over 64-bit operands.
- Holds the stall line high so the pipeline registers freeze while the multiply runs.
- Presents a one-cycle-valid 64-bit result that the EX-stage ALU result mux selects.

---
 rtl/mul_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_mul_seq_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative shift-add multiplier that stalls the EX stage while it runs.
// Optional MUL_SEQ_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
`default_nettype none

module mul_seq_ctrl #(
  parameter int DATA_W         = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              enable,
  input  logic              start,
  input  logic [2:0]        func3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              stall,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] result
);

  localparam int N     = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [2*DATA_W-1:0]     mcand_q, mcand_d;
  logic [DATA_W-1:0]       mplier_q, mplier_d;
  logic [2*DATA_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sel_hi_q, sel_hi_d;
  logic [DATA_W-1:0]       result_q, result_d;

  logic [2*DATA_W-1:0]     part_sum;
  logic [2*DATA_W-1:0]     acc_upd;
  logic [DATA_W-1:0]       mplier_shift;
  logic                    unused_func3;

  // Only func3[1] distinguishes MULHU from MUL; the other bits are don't-care.
  assign unused_func3 = ^{func3[2], func3[0]};

  always_comb begin
    part_sum = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mplier_q[k]) part_sum = part_sum + (mcand_q << k);
    end
    acc_upd      = acc_q + part_sum;
    mplier_shift = mplier_q >> BITS_PER_CYCLE;
  end

  always_comb begin
    state_d      = state_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    sel_hi_d     = sel_hi_q;
    result_d     = result_q;
    stall        = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;

    case (state_q)
      IDLE: begin
        stall = start;
        if (start) begin
          mcand_d  = {{DATA_W{1'b0}}, op_a};
          mplier_d = op_b;
          sel_hi_d = func3[1];
          acc_d    = '0;
          cnt_d    = CNT_W'(N);
          state_d  = BUSY;
`ifdef MUL_SEQ_EARLY_TERM_EN
          if (op_b == '0) begin
            result_d = '0;
            state_d  = DONE;
          end
`endif
        end
      end
      BUSY: begin
        stall    = 1'b1;
        busy     = 1'b1;
        acc_d    = acc_upd;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_shift;
        cnt_d    = cnt_q - CNT_W'(1);
`ifdef MUL_SEQ_EARLY_TERM_EN
        if ((cnt_q == CNT_W'(1)) || (mplier_shift == '0)) begin
`else
        if (cnt_q == CNT_W'(1)) begin
`endif
          result_d = sel_hi_q ? acc_upd[2*DATA_W-1:DATA_W] : acc_upd[DATA_W-1:0];
          state_d  = DONE;
        end
      end
      DONE: begin
        // start is still the same instruction here, so it is not re-examined.
        result_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sel_hi_q <= 1'b0;
      result_q <= '0;
    end else if (enable) begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sel_hi_q <= sel_hi_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed vectors for mul_seq_ctrl at 1 and 4 multiplier bits per cycle.
`default_nettype none

module tb_mul_seq_ctrl;

  logic        clk;
  logic        srst;
  logic        enable;
  logic        start_r;
  logic        sel4;
  logic [2:0]  func3;
  logic [63:0] op_a;
  logic [63:0] op_b;

  logic        start1, start4;
  logic        stall1, busy1, valid1;
  logic        stall4, busy4, valid4;
  logic [63:0] result1, result4;
  logic        stall, busy, valid;
  logic [63:0] result;

  int n_cmp = 0;
  int n_err = 0;

  assign start1 = start_r & ~sel4;
  assign start4 = start_r & sel4;
  assign stall  = sel4 ? stall4  : stall1;
  assign busy   = sel4 ? busy4   : busy1;
  assign valid  = sel4 ? valid4  : valid1;
  assign result = sel4 ? result4 : result1;

  mul_seq_ctrl #(.DATA_W(64), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .srst(srst), .enable(enable), .start(start1), .func3(func3),
    .op_a(op_a), .op_b(op_b), .stall(stall1), .busy(busy1),
    .result_valid(valid1), .result(result1)
  );

  mul_seq_ctrl #(.DATA_W(64), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .srst(srst), .enable(enable), .start(start4), .func3(func3),
    .op_a(op_a), .op_b(op_b), .stall(stall4), .busy(busy4),
    .result_valid(valid4), .result(result4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one request at a negedge and counts stall cycles until DONE.
  task automatic run_mul(input string tag, input logic use4, input logic [63:0] a,
                         input logic [63:0] b, input logic [2:0] f3, input int exp_stall,
                         input logic [63:0] exp_res, input int pause_at);
    int n;
    logic timed_out;
    n = 0;
    timed_out = 1'b0;
    @(negedge clk);
    sel4 = use4; op_a = a; op_b = b; func3 = f3; start_r = 1'b1;
    #1;
    while (stall === 1'b1) begin
      n++;
      if (n == 2) chk({tag, "_busy"}, 64'(busy), 64'd1);
      if (n == pause_at)     enable = 1'b0;
      if (n == pause_at + 5) enable = 1'b1;
      if (n > 300) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (timed_out) begin
      chk({tag, "_timeout"}, 64'(n), 64'(exp_stall));
      enable = 1'b1;
    end else begin
      chk({tag, "_stall_cycles"}, 64'(n), 64'(exp_stall));
      chk({tag, "_valid"}, 64'(valid), 64'd1);
      chk({tag, "_result"}, result, exp_res);
    end
    start_r = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_valid_drop"}, 64'(valid), 64'd0);
    chk({tag, "_result_hold"}, result, exp_res);
  endtask

  initial begin
    int n;
    srst = 1'b1; enable = 1'b1; start_r = 1'b0; sel4 = 1'b0;
    func3 = 3'b000; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall",  64'(stall1), 64'd0);
    chk("rst_busy",   64'(busy1),  64'd0);
    chk("rst_valid",  64'(valid1), 64'd0);
    chk("rst_result", result1,     64'd0);
    chk("rst_result4", result4,    64'd0);
    srst = 1'b0;

`ifdef MUL_SEQ_EARLY_TERM_EN
    run_mul("mul3x5",    1'b0, 64'd3, 64'd5, 3'b000, 4, 64'd15, -1);
    run_mul("mulhu_max", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'b011, 3, 64'd1, -1);
    run_mul("mul_max",   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'b000, 3,
            64'hFFFF_FFFF_FFFF_FFFE, -1);
    run_mul("bpc4",      1'b1, 64'h1234_5678, 64'h9ABC_DEF0, 3'b000, 9,
            64'h0B00_EA4E_242D_2080, -1);
    run_mul("op_b_one",  1'b0, 64'd7, 64'd1, 3'b000, 2, 64'd7, -1);
    run_mul("op_b_zero", 1'b0, 64'd7, 64'd0, 3'b000, 1, 64'd0, -1);
`else
    run_mul("mul3x5",    1'b0, 64'd3, 64'd5, 3'b000, 65, 64'd15, -1);
    run_mul("mulhu_max", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'b011, 65, 64'd1, -1);
    run_mul("mul_max",   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'b000, 65,
            64'hFFFF_FFFF_FFFF_FFFE, -1);
    run_mul("bpc4",      1'b1, 64'h1234_5678, 64'h9ABC_DEF0, 3'b000, 17,
            64'h0B00_EA4E_242D_2080, -1);
    run_mul("op_b_one",  1'b0, 64'd7, 64'd1, 3'b000, 65, 64'd7, -1);
    run_mul("op_b_zero", 1'b0, 64'd7, 64'd0, 3'b000, 65, 64'd0, -1);
`endif

    // Top multiplier bit set keeps the full latency in either build.
    run_mul("pause", 1'b0, 64'hDEAD_BEEF, 64'h8000_0000_0000_0001, 3'b000, 70,
            64'h8000_0000_DEAD_BEEF, 10);
    run_mul("mulhu_pause", 1'b0, 64'hDEAD_BEEF, 64'h8000_0000_0000_0001, 3'b011, 70,
            64'h0000_0000_6F56_DF77, 3);

    // Reset in the middle of a run; result from the previous op is nonzero.
    n = 0;
    @(negedge clk);
    sel4 = 1'b0; op_a = 64'd3; op_b = 64'h8000_0000_0000_0005; func3 = 3'b000; start_r = 1'b1;
    #1;
    while (stall1 === 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("midrst_running", 64'(busy1), 64'd1);
    srst = 1'b1; start_r = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_stall",  64'(stall1), 64'd0);
    chk("midrst_busy",   64'(busy1),  64'd0);
    chk("midrst_valid",  64'(valid1), 64'd0);
    chk("midrst_result", result1,     64'd0);
    srst = 1'b0;
`ifdef MUL_SEQ_EARLY_TERM_EN
    run_mul("after_rst", 1'b0, 64'd3, 64'd5, 3'b000, 4, 64'd15, -1);
`else
    run_mul("after_rst", 1'b0, 64'd3, 64'd5, 3'b000, 65, 64'd15, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
